// File: rtl/pack_pkg.sv
// Shared constants for the TX packer and RX unpacker.
// Lane geometry and fill-level widths live here.
package pack_pkg;
  localparam int NUM_OF_CHANNELS = 4;
  localparam int CHANNEL_WIDTH   = 16;
  localparam int LANE_W          = CHANNEL_WIDTH;
  localparam int CHAN_COUNT_W    = $clog2(NUM_OF_CHANNELS + 1);
  localparam int FILL_W          = 2;
  localparam int HOLD_LANES      = NUM_OF_CHANNELS - 1;
  localparam int WIN_LANES       = 2 * NUM_OF_CHANNELS - 1;
  localparam int WORD_W          = NUM_OF_CHANNELS * LANE_W;

  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/packer_lane_place.sv
// Places N samples after the occupied hold lanes in a 7-lane window.
// Lanes past fill+N come out zero.
module packer_lane_place
  import pack_pkg::*;
(
  input  logic [HOLD_LANES*LANE_W-1:0]   hold,
  input  logic [FILL_W-1:0]              fill,
  input  logic [CHAN_COUNT_W-1:0]        cnt,
  input  logic [WORD_W-1:0]              samples,
  output logic [WIN_LANES*LANE_W-1:0]    window
);

  logic [HOLD_LANES-1:0][LANE_W-1:0]      hold_l;
  logic [NUM_OF_CHANNELS-1:0][LANE_W-1:0] samp_l;
  logic [WIN_LANES-1:0][LANE_W-1:0]       win_l;
  logic [2:0]                             fill_x;

  assign hold_l = hold;
  assign samp_l = samples;
  assign fill_x = {1'b0, fill};
  assign window = win_l;

  always_comb begin
    win_l = '0;
    for (int j = 0; j < HOLD_LANES; j++) begin
      if (3'(j) < fill_x)
        win_l[j] = hold_l[j];
    end
    // sample k lands in lane fill+k; all indices stay constant
    for (int j = 0; j < WIN_LANES; j++) begin
      for (int k = 0; k < NUM_OF_CHANNELS; k++) begin
        if ((3'(k) < cnt) && (fill_x + 3'(k) == 3'(j)))
          win_l[j] = samp_l[k];
      end
    end
  end

endmodule

// File: rtl/packer.sv
// TX packer: densely packs per-channel samples into 4-lane words.
// Flush emits a zero-padded partial word on the next idle cycle.
module packer
  import pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHAN_COUNT_W-1:0] enabled_chan_count,
  input  logic [LANE_W-1:0]       data_in_0,
  input  logic [LANE_W-1:0]       data_in_1,
  input  logic [LANE_W-1:0]       data_in_2,
  input  logic [LANE_W-1:0]       data_in_3,
  input  logic                    data_in_valid,
  input  logic                    flush,
  output logic [WORD_W-1:0]       data_out,
  output logic                    data_out_valid,
  output logic                    data_out_partial
);

  logic [CHAN_COUNT_W-1:0]          cnt_q;
  logic [FILL_W-1:0]                fill_q;
  logic [HOLD_LANES-1:0][LANE_W-1:0] hold_q;
  logic                             flush_pend;

  logic                             active;
  logic [2:0]                       sum;
  logic [WIN_LANES-1:0][LANE_W-1:0] win;
  logic [WORD_W-1:0]                samples;
  logic [NUM_OF_CHANNELS-1:0][LANE_W-1:0] part_word;

  assign active  = (cnt_q != '0) && (cnt_q <= 3'(NUM_OF_CHANNELS));
  assign sum     = {1'b0, fill_q} + cnt_q;
  assign samples = {data_in_3, data_in_2, data_in_1, data_in_0};

  packer_lane_place u_place (
    .hold    (hold_q),
    .fill    (fill_q),
    .cnt     (cnt_q),
    .samples (samples),
    .window  (win)
  );

  always_comb begin
    part_word = '0;
    for (int j = 0; j < HOLD_LANES; j++) begin
      if (3'(j) < {1'b0, fill_q})
        part_word[j] = hold_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q            <= enabled_chan_count;
      fill_q           <= '0;
      hold_q           <= '0;
      flush_pend       <= 1'b0;
      data_out         <= '0;
      data_out_valid   <= 1'b0;
      data_out_partial <= 1'b0;
    end else begin
      data_out         <= '0;
      data_out_valid   <= 1'b0;
      data_out_partial <= 1'b0;
      if (active) begin
        if (data_in_valid) begin
          flush_pend <= flush_pend | flush;
          if (sum >= 3'd4) begin
            data_out       <= win[NUM_OF_CHANNELS-1:0];
            data_out_valid <= 1'b1;
            hold_q         <= win[WIN_LANES-1:NUM_OF_CHANNELS];
            fill_q         <= 2'(sum - 3'd4);
          end else begin
            hold_q <= win[HOLD_LANES-1:0];
            fill_q <= sum[FILL_W-1:0];
          end
        end else if (flush_pend || flush) begin
          flush_pend <= 1'b0;
          if (fill_q != '0) begin
            data_out         <= part_word;
            data_out_valid   <= 1'b1;
            data_out_partial <= 1'b1;
            fill_q           <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_packer.sv
// Directed bench for packer: word formation, flush padding,
// reset re-latching of the channel count and the idle mode.
module tb_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cnt;
  logic [15:0] d0, d1, d2, d3;
  logic        vin;
  logic        flush;
  logic [63:0] dout;
  logic        vout;
  logic        pout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packer dut (
    .clk                (clk),
    .reset              (reset),
    .enabled_chan_count (cnt),
    .data_in_0          (d0),
    .data_in_1          (d1),
    .data_in_2          (d2),
    .data_in_3          (d3),
    .data_in_valid      (vin),
    .flush              (flush),
    .data_out           (dout),
    .data_out_valid     (vout),
    .data_out_partial   (pout)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic p, input logic [63:0] d);
    chk({tag, ".valid"}, {63'd0, vout}, {63'd0, v});
    chk({tag, ".partial"}, {63'd0, pout}, {63'd0, p});
    chk({tag, ".data"}, dout, d);
  endtask

  task automatic drive(input logic v, input logic f,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    vin = v; flush = f;
    d0 = a; d1 = b; d2 = c; d3 = d;
  endtask

  task automatic do_reset(input logic [2:0] n);
    reset = 1'b1; cnt = n;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cnt = 3'd4;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);

    // reset state
    do_reset(3'd4);
    chk_out("reset", 1'b0, 1'b0, 64'h0);

    // 1: four channels, one word per input cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'(16 * i), 16'(16 * i + 1),
            16'(16 * i + 2), 16'(16 * i + 3));
      step();
      chk_out($sformatf("c4.w%0d", i), 1'b1, 1'b0,
              {16'(16 * i + 3), 16'(16 * i + 2),
               16'(16 * i + 1), 16'(16 * i)});
    end
    drive(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c4.flush_empty", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c4.idle", 1'b0, 1'b0, 64'h0);

    // 2: three channels, 3 words per 4 inputs
    do_reset(3'd3);
    drive(1'b1, 1'b0, 16'hA0, 16'hA1, 16'hA2, 16'hFFFF);
    step();
    chk_out("c3.in1", 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'hB0, 16'hB1, 16'hB2, 16'hFFFF);
    step();
    chk_out("c3.in2", 1'b1, 1'b0, {16'hB0, 16'hA2, 16'hA1, 16'hA0});
    drive(1'b1, 1'b0, 16'hC0, 16'hC1, 16'hC2, 16'hFFFF);
    step();
    chk_out("c3.in3", 1'b1, 1'b0, {16'hC1, 16'hC0, 16'hB2, 16'hB1});
    drive(1'b1, 1'b0, 16'hD0, 16'hD1, 16'hD2, 16'hFFFF);
    step();
    chk_out("c3.in4", 1'b1, 1'b0, {16'hD2, 16'hD1, 16'hD0, 16'hC2});
    drive(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c3.flush_empty", 1'b0, 1'b0, 64'h0);

    // 3: one channel, six samples then flush
    do_reset(3'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'(16'h11 + i), 16'hEEEE, 16'hEEEE, 16'hEEEE);
      step();
      if (i == 3)
        chk_out("c1.word", 1'b1, 1'b0,
                {16'h14, 16'h13, 16'h12, 16'h11});
      else
        chk_out($sformatf("c1.in%0d", i), 1'b0, 1'b0, 64'h0);
    end
    drive(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c1.flush", 1'b1, 1'b1, {16'h0, 16'h0, 16'h16, 16'h15});
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c1.after", 1'b0, 1'b0, 64'h0);

    // 4: two channels, flush coincides with the first valid
    do_reset(3'd2);
    drive(1'b1, 1'b1, 16'h21, 16'h22, 16'hDDDD, 16'hDDDD);
    step();
    chk_out("c2.flush_valid", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("c2.pend_flush", 1'b1, 1'b1, {16'h0, 16'h0, 16'h22, 16'h21});
    step();
    chk_out("c2.after", 1'b0, 1'b0, 64'h0);

    // 5: reset mid-word drops held data and re-latches count
    do_reset(3'd3);
    drive(1'b1, 1'b0, 16'h31, 16'h32, 16'h33, 16'h0);
    step();
    chk_out("rst.in1", 1'b0, 1'b0, 64'h0);
    do_reset(3'd2);
    chk_out("rst.during", 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h41, 16'h42, 16'hCCCC, 16'hCCCC);
    step();
    chk_out("rst.in_a", 1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 16'h43, 16'h44, 16'hCCCC, 16'hCCCC);
    step();
    chk_out("rst.in_b", 1'b1, 1'b0, {16'h44, 16'h43, 16'h42, 16'h41});
    cnt = 3'd1;
    drive(1'b1, 1'b0, 16'h45, 16'h46, 16'hCCCC, 16'hCCCC);
    step();
    chk_out("rst.cnt_ignored", 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    chk_out("rst.cnt_flush", 1'b1, 1'b1, {16'h0, 16'h0, 16'h46, 16'h45});

    // 6: count 0 is idle regardless of inputs
    do_reset(3'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(1)), 1'($urandom_range(1)),
            16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));
      step();
      chk($sformatf("c0.valid%0d", i), {63'd0, vout}, 64'h0);
      chk($sformatf("c0.data%0d", i), dout, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
